vga_pong_pixel_source: RTL and testbench
========================================

Name: vga_pong_pixel_source

Overview:
- Generates 640x480@60 Hz VGA timing and renders the Pong scene (ball, two paddles, dashed net).
- Drives the bright / pixel / colors inputs of the VGA colour-bit generator, plus hsync/vsync to the DAC connector.
- Game-logic positions are sampled once per frame at the start of vertical blanking, so the picture never tears.

Parameters:
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_L_X, 16, left paddle left edge x
- PADDLE_R_X, 616, right paddle left edge x
- BALL_SIZE, 8, ball side length in pixels (square)
- NET_X, 319, net left edge x; net is 2 px wide

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- paddle_l_y  in  10  left paddle top edge y
- paddle_r_y  in  10  right paddle top edge y
- ball_x  in  10  ball left edge x
- ball_y  in  10  ball top edge y
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- bright  out  1  high inside the 640x480 visible area
- pixel  out  1  high when an object covers the current pixel
- colors  out  3  colour code: 000 white, 001 cyan, 010 red
- hcount  out  10  current horizontal pixel count, 0..799
- vcount  out  10  current line count, 0..524
- pix_tick  out  1  25 MHz pixel enable, one clk wide
- frame_start  out  1  one-clk pulse on frame wrap

Behaviour:
- Reset (synchronous, active-high): divider=0, hcount=0, vcount=0, hsync=1, vsync=1, bright=0, pixel=0, colors=000, frame_start=0.
- Reset latched positions: paddles y=208, ball (316,236).
- Reset asserted mid-frame restarts timing from (0,0) on the next edge.
- pix_tick: 1-bit divider toggles every clk; pix_tick=1 when divider==1.
  - First pix_tick is on the 2nd clk after rst deasserts.
  - Thereafter every 2 clks.
- Counters advance only on pix_tick.
  - hcount wraps 799->0.
  - vcount increments when hcount wraps, and wraps 524->0.
- frame_start: one-clk pulse on the pix_tick where (799,524) -> (0,0).
- Horizontal: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Registered decode stage: hsync, vsync, bright, pixel and colors are decoded from the current hcount/vcount and lag them by exactly 1 clk.
  - These outputs settle within the same pixel period.
- hsync=0 iff 656<=hcount<=751. vsync=0 iff 490<=vcount<=491. bright=1 iff hcount<640 and vcount<480.
- Position latch: on the pix_tick where hcount==0 and vcount==480, sample all four position inputs into internal registers.
  - Input changes at any other time have no visible effect until the next latch.
- Clamping at latch:
  - paddle y > 480-PADDLE_H -> stored as 480-PADDLE_H.
  - ball_x > 640-BALL_SIZE -> stored as 640-BALL_SIZE.
  - ball_y > 480-BALL_SIZE -> stored as 480-BALL_SIZE.
- Hit tests use latched values with inclusive left/top and exclusive right/bottom edges.
  - Ball: bx<=h<bx+BALL_SIZE and by<=v<by+BALL_SIZE.
  - Paddle: PADDLE_*_X<=h<PADDLE_*_X+PADDLE_W and py<=v<py+PADDLE_H.
  - Net: NET_X<=h<=NET_X+1 and vcount[4]==0 (16-line dashes).
- Priority: ball (colors 000) > paddle (001) > net (010).
- pixel=1 iff any hit and bright=1.
- When pixel=0, colors=000. Outside the visible area, pixel=0 and colors=000.
- Arithmetic is 11-bit internally so edge sums do not overflow 10 bits.

Test Plan:
- Reset release -> hsync=vsync=1, bright=0, first pix_tick on the 2nd clk, hcount increments every 2 clks.
- Free run, measure sync timing:
  - hsync low for exactly 96 ticks (192 clks), starting at hcount=656; line period 1600 clks.
  - vsync low for exactly 2 lines; frame_start period 840000 clks.
- Count bright-high pixel ticks over one frame -> exactly 307200. pixel never 1 while bright=0.
- Ball (100,100), paddles y=300 -> pixel=1, colors=000 for h,v in 100..107 only.
  - Left paddle: colors=001 at h 16..23, v 300..363.
  - Net: colors=010 at h=319, v=5; pixel=0 at v=20.
- Ball (16,300) overlapping left paddle -> colors=000 at (16,300). paddle_r_y=470 -> rendered at v 416..479.
- Change ball_x to 400 at vcount=200 -> old position drawn until frame end; new position appears from next frame.
- Assert rst at vcount=250 -> next clk: hcount=vcount=0, outputs at reset values.

Source files
------------

// File: rtl/vga_pong_pixel_source.sv
// ============================================================================
// Module      : vga_pong_pixel_source
// Description : 640x480@60 VGA timing plus Pong scene renderer (ball,
//               paddles, dashed net) with per-frame position latching.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pong_pixel_source #(
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_H   = 64,
    parameter int PADDLE_L_X = 16,
    parameter int PADDLE_R_X = 616,
    parameter int BALL_SIZE  = 8,
    parameter int NET_X      = 319
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic       pixel,
    output logic [2:0] colors,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam logic [9:0]  c_h_last     = 10'd799;
    localparam logic [9:0]  c_v_last     = 10'd524;
    localparam logic [9:0]  c_h_visible  = 10'd640;
    localparam logic [9:0]  c_v_visible  = 10'd480;
    localparam logic [9:0]  c_hs_start   = 10'd656;
    localparam logic [9:0]  c_hs_end     = 10'd751;
    localparam logic [9:0]  c_vs_start   = 10'd490;
    localparam logic [9:0]  c_vs_end     = 10'd491;
    localparam logic [9:0]  c_latch_line = 10'd480;

    localparam logic [9:0]  c_pad_y_max  = 10'(480 - PADDLE_H);
    localparam logic [9:0]  c_ball_x_max = 10'(640 - BALL_SIZE);
    localparam logic [9:0]  c_ball_y_max = 10'(480 - BALL_SIZE);
    localparam logic [9:0]  c_pad_y_rst  = 10'((480 - PADDLE_H) / 2);
    localparam logic [9:0]  c_ball_x_rst = 10'((640 - BALL_SIZE) / 2);
    localparam logic [9:0]  c_ball_y_rst = 10'((480 - BALL_SIZE) / 2);

    localparam logic [10:0] c_ball_sz    = 11'(BALL_SIZE);
    localparam logic [10:0] c_pad_w      = 11'(PADDLE_W);
    localparam logic [10:0] c_pad_h      = 11'(PADDLE_H);
    localparam logic [10:0] c_pad_l_x    = 11'(PADDLE_L_X);
    localparam logic [10:0] c_pad_r_x    = 11'(PADDLE_R_X);
    localparam logic [10:0] c_net_x      = 11'(NET_X);

    logic       r_div;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [9:0] r_pad_l_y;
    logic [9:0] r_pad_r_y;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;

    assign pix_tick = r_div;
    assign hcount   = r_hcount;
    assign vcount   = r_vcount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= 1'b0;
        end else begin
            r_div <= ~r_div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= r_div && (r_hcount == c_h_last) && (r_vcount == c_v_last);
            if (r_div) begin
                if (r_hcount == c_h_last) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == c_v_last) ? 10'd0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    // Positions only change at the top of vertical blanking so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad_l_y <= c_pad_y_rst;
            r_pad_r_y <= c_pad_y_rst;
            r_ball_x  <= c_ball_x_rst;
            r_ball_y  <= c_ball_y_rst;
        end else if (r_div && (r_hcount == 10'd0) && (r_vcount == c_latch_line)) begin
            r_pad_l_y <= (paddle_l_y > c_pad_y_max)  ? c_pad_y_max  : paddle_l_y;
            r_pad_r_y <= (paddle_r_y > c_pad_y_max)  ? c_pad_y_max  : paddle_r_y;
            r_ball_x  <= (ball_x     > c_ball_x_max) ? c_ball_x_max : ball_x;
            r_ball_y  <= (ball_y     > c_ball_y_max) ? c_ball_y_max : ball_y;
        end
    end

    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_visible;
    logic        w_hit_ball;
    logic        w_hit_pad_l;
    logic        w_hit_pad_r;
    logic        w_hit_net;
    logic [2:0]  w_color;

    assign w_h       = {1'b0, r_hcount};
    assign w_v       = {1'b0, r_vcount};
    assign w_visible = (r_hcount < c_h_visible) && (r_vcount < c_v_visible);

    assign w_hit_ball  = (w_h >= {1'b0, r_ball_x}) && (w_h < ({1'b0, r_ball_x} + c_ball_sz)) &&
                         (w_v >= {1'b0, r_ball_y}) && (w_v < ({1'b0, r_ball_y} + c_ball_sz));
    assign w_hit_pad_l = (w_h >= c_pad_l_x) && (w_h < (c_pad_l_x + c_pad_w)) &&
                         (w_v >= {1'b0, r_pad_l_y}) && (w_v < ({1'b0, r_pad_l_y} + c_pad_h));
    assign w_hit_pad_r = (w_h >= c_pad_r_x) && (w_h < (c_pad_r_x + c_pad_w)) &&
                         (w_v >= {1'b0, r_pad_r_y}) && (w_v < ({1'b0, r_pad_r_y} + c_pad_h));
    // Dashes of 16 lines on, 16 lines off.
    assign w_hit_net   = (w_h >= c_net_x) && (w_h <= (c_net_x + 11'd1)) && !r_vcount[4];

    always_comb begin
        w_color = 3'b000;
        if (w_visible) begin
            if (w_hit_ball) begin
                w_color = 3'b000;
            end else if (w_hit_pad_l || w_hit_pad_r) begin
                w_color = 3'b001;
            end else if (w_hit_net) begin
                w_color = 3'b010;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            bright <= 1'b0;
            pixel  <= 1'b0;
            colors <= 3'b000;
        end else begin
            hsync  <= !((r_hcount >= c_hs_start) && (r_hcount <= c_hs_end));
            vsync  <= !((r_vcount >= c_vs_start) && (r_vcount <= c_vs_end));
            bright <= w_visible;
            pixel  <= w_visible && (w_hit_ball || w_hit_pad_l || w_hit_pad_r || w_hit_net);
            colors <= w_color;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_pong_pixel_source.sv
// ============================================================================
// Module      : tb_vga_pong_pixel_source
// Description : Self-checking bench for vga_pong_pixel_source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pong_pixel_source;

    localparam int FRAME_TICKS = 800 * 525;

    typedef struct {
        int pl;
        int pr;
        int bx;
        int by;
    } pos_t;

    typedef struct {
        int         f;
        int         h;
        int         v;
        logic       exp_pixel;
        logic [2:0] exp_colors;
    } probe_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] paddle_l_y = '0;
    logic [9:0] paddle_r_y = '0;
    logic [9:0] ball_x = '0;
    logic [9:0] ball_y = '0;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic       pixel;
    logic [2:0] colors;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       pix_tick;
    logic       frame_start;

    vga_pong_pixel_source dut (
        .clk        (clk),
        .rst        (rst),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .bright     (bright),
        .pixel      (pixel),
        .colors     (colors),
        .hcount     (hcount),
        .vcount     (vcount),
        .pix_tick   (pix_tick),
        .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    int     k;
    pos_t   lat;
    pos_t   lat_prev;
    probe_t probes[25];
    bit     first_run;
    int     bright_ticks;
    int     hs_low_clks;
    int     vs_low_clks;
    int     pix_no_bright;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (clk %0d after reset release)", nm, act, exp, k);
        end
    endtask

    function automatic pos_t reset_pos();
        pos_t p;
        p.pl = 208; p.pr = 208; p.bx = 316; p.by = 236;
        return p;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic pos_t clamp_pos(input int pl, input int pr, input int bx, input int by);
        pos_t p;
        p.pl = min_i(pl, 480 - 64);
        p.pr = min_i(pr, 480 - 64);
        p.bx = min_i(bx, 640 - 8);
        p.by = min_i(by, 480 - 8);
        return p;
    endfunction

    // Scene rules from the drawing description: ball over paddles over net.
    task automatic scene(input int h, input int v, input pos_t p,
                         output logic pix, output logic [2:0] col);
        bit vis, b, pd, nt;
        vis = (h < 640) && (v < 480);
        b   = (h >= p.bx) && (h < p.bx + 8) && (v >= p.by) && (v < p.by + 8);
        pd  = ((h >= 16) && (h < 24) && (v >= p.pl) && (v < p.pl + 64)) ||
              ((h >= 616) && (h < 624) && (v >= p.pr) && (v < p.pr + 64));
        nt  = ((h == 319) || (h == 320)) && (((v / 16) % 2) == 0);
        pix = vis && (b || pd || nt);
        col = 3'b000;
        if (vis && !b && pd)       col = 3'b001;
        else if (vis && !b && nt)  col = 3'b010;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hcount"},      int'(hcount), 0);
        check({tag, "_vcount"},      int'(vcount), 0);
        check({tag, "_hsync"},       int'(hsync), 1);
        check({tag, "_vsync"},       int'(vsync), 1);
        check({tag, "_bright"},      int'(bright), 0);
        check({tag, "_pixel"},       int'(pixel), 0);
        check({tag, "_colors"},      int'(colors), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_pix_tick"},    int'(pix_tick), 0);
    endtask

    task automatic run_until(input int k_end);
        int nc, nd, dh, dv, key;
        logic       e_pix;
        logic [2:0] e_col;
        while ((k < k_end) && (n_errors < 30)) begin
            @(posedge clk);
            k++;
            lat_prev = lat;
            if ((k % 2 == 0) && (((k / 2 - 1) % FRAME_TICKS) == 480 * 800))
                lat = clamp_pos(paddle_l_y, paddle_r_y, ball_x, ball_y);
            @(negedge clk);
            nc = k / 2;
            nd = (k - 1) / 2;
            dh = nd % 800;
            dv = (nd / 800) % 525;
            scene(dh, dv, lat_prev, e_pix, e_col);
            check("hcount",      int'(hcount), nc % 800);
            check("vcount",      int'(vcount), (nc / 800) % 525);
            check("pix_tick",    int'(pix_tick), k % 2);
            check("frame_start", int'(frame_start),
                  ((k % 2 == 0) && (nc > 0) && (nc % FRAME_TICKS == 0)) ? 1 : 0);
            check("hsync",       int'(hsync), ((dh >= 656) && (dh <= 751)) ? 0 : 1);
            check("vsync",       int'(vsync), ((dv == 490) || (dv == 491)) ? 0 : 1);
            check("bright",      int'(bright), ((dh < 640) && (dv < 480)) ? 1 : 0);
            check("pixel",       int'(pixel), int'(e_pix));
            check("colors",      int'(colors), int'(e_col));
            if (k % 2 == 1) begin
                for (int i = 0; i < 25; i++) begin
                    key = probes[i].f * FRAME_TICKS + probes[i].v * 800 + probes[i].h;
                    if (key == nd) begin
                        check($sformatf("probe%0d_pixel", i),  int'(pixel),  int'(probes[i].exp_pixel));
                        check($sformatf("probe%0d_colors", i), int'(colors), int'(probes[i].exp_colors));
                    end
                end
            end
            if (first_run) begin
                if ((k % 2 == 1) && (k < 2 * FRAME_TICKS) && bright) bright_ticks++;
                if ((k >= 1601) && (k <= 3200) && !hsync) hs_low_clks++;
                if ((k <= 2 * FRAME_TICKS) && !vsync) vs_low_clks++;
            end
            if (pixel && !bright) pix_no_bright++;
            // Fixed positions only around the latch edge; noise elsewhere must not show.
            if ((k >= 767990) && (k <= 768010)) begin
                paddle_l_y = 10'd470;
                paddle_r_y = 10'd1000;
                ball_x     = 10'd20;
                ball_y     = 10'd900;
            end else begin
                paddle_l_y = 10'($urandom_range(0, 1023));
                paddle_r_y = 10'($urandom_range(0, 1023));
                ball_x     = 10'($urandom_range(0, 1023));
                ball_y     = 10'($urandom_range(0, 1023));
            end
        end
    endtask

    initial begin
        // Frame 0 uses reset positions; frame 1 uses the clamped latch values.
        probes[0]  = '{0, 316, 236, 1'b1, 3'b000};
        probes[1]  = '{0, 323, 243, 1'b1, 3'b000};
        probes[2]  = '{0, 324, 236, 1'b0, 3'b000};
        probes[3]  = '{0, 319,   5, 1'b1, 3'b010};
        probes[4]  = '{0, 319,  20, 1'b0, 3'b000};
        probes[5]  = '{0, 320, 244, 1'b0, 3'b000};
        probes[6]  = '{0,  16, 208, 1'b1, 3'b001};
        probes[7]  = '{0,  23, 271, 1'b1, 3'b001};
        probes[8]  = '{0,  24, 208, 1'b0, 3'b000};
        probes[9]  = '{0, 616, 208, 1'b1, 3'b001};
        probes[10] = '{0,  16, 272, 1'b0, 3'b000};
        probes[11] = '{0, 640,   0, 1'b0, 3'b000};
        probes[12] = '{0, 319, 236, 1'b1, 3'b000};
        probes[13] = '{1,  20, 472, 1'b1, 3'b000};
        probes[14] = '{1,  16, 472, 1'b1, 3'b001};
        probes[15] = '{1,  24, 416, 1'b0, 3'b000};
        probes[16] = '{1,  27, 479, 1'b1, 3'b000};
        probes[17] = '{1,  28, 479, 1'b0, 3'b000};
        probes[18] = '{1, 616, 416, 1'b1, 3'b001};
        probes[19] = '{1, 623, 479, 1'b1, 3'b001};
        probes[20] = '{1, 616, 415, 1'b0, 3'b000};
        probes[21] = '{1, 316, 236, 1'b0, 3'b000};
        probes[22] = '{1, 319,  32, 1'b1, 3'b010};
        probes[23] = '{1, 319,  48, 1'b0, 3'b000};
        probes[24] = '{1,  20, 480, 1'b0, 3'b000};

        bright_ticks  = 0;
        hs_low_clks   = 0;
        vs_low_clks   = 0;
        pix_no_bright = 0;
        k             = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        rst       = 1'b0;
        k         = 0;
        lat       = reset_pos();
        first_run = 1'b1;
        // Run into frame 1, stopping inside its vsync pulse.
        run_until(2 * (FRAME_TICKS + 491 * 800 + 100));

        if (n_errors < 30) begin
            check("frame0_bright_ticks", bright_ticks, 640 * 480);
            check("line1_hsync_low_clks", hs_low_clks, 192);
            check("frame0_vsync_low_clks", vs_low_clks, 2 * 1600);
            check("vsync_low_before_reset", int'(vsync), 0);

            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("midframe_reset");
            rst       = 1'b0;
            k         = 0;
            lat       = reset_pos();
            first_run = 1'b0;
            run_until(3300);
        end

        check("pixel_outside_bright", pix_no_bright, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
